core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle fetch/decode/execute controller for the 8-bit datapath; it sits directly upstream of the 8×8 register file. It fetches 16-bit instructions from instruction memory over a valid handshake and drives the register file's read addresses. It consumes the file's registered read data and computes results through an ALU. It then issues a single-cycle write-back. Register 7 is an externally driven input inside the register file, so this block never writes it.

## Interface
- PC_W, 6, program counter width (instruction memory depth 2^PC_W)
- DATA_W, 8, datapath width (must match the register file)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: leave IDLE/HALT and begin fetching at pc=0
- imem_req  out  1  fetch request, held until accepted
- pc  out  PC_W  fetch address
- imem_valid  in  1  instr is valid this cycle
- instr  in  16  instruction word
- rf_a1, rf_a2  out  3  register file read addresses
- rf_a3  out  3  register file write address
- rf_we  out  1  register file write enable
- rf_wd  out  DATA_W  register file write data
- rf_rd1, rf_rd2  in  DATA_W  register file read data (registered, one-cycle latency)
- halted  out  1  high while in HALT
- flag_z, flag_c  out  1  zero and carry/borrow from the last ALU op

## Operation
- Instruction fields:
  - op=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0], tgt=[PC_W-1:0]
- Opcodes:
  - 0 NOP
  - 1 ADD: rd=rs1+rs2
  - 2 SUB: rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 LI: rd=imm8
  - 7 MOV: rd=rs1
  - 8 BEQZ: if rs1==0 then pc=tgt
  - 15 HALT
  - 9–14 execute as NOP
- FSM states: IDLE, FETCH, DECODE, READ, WB, HALT.
  - IDLE: start → FETCH, with pc=0.
  - FETCH: imem_req=1. On imem_valid, latch instr and go to DECODE. Otherwise stay, holding pc and imem_req.
  - DECODE: rf_a1=rs1 and rf_a2=rs2 from the latched instruction. Go to READ. HALT goes directly to HALT.
  - READ: rf_rd1/rf_rd2 are valid. The ALU result is registered into rf_wd and the next pc is computed. Go to WB.
  - WB: rf_we=1 for exactly this cycle, only for ADD/SUB/AND/OR/XOR/LI/MOV with rd≠7. pc takes next_pc. Go to FETCH.
  - HALT: halted=1. start → pc=0, FETCH. All other inputs are ignored.
- Arithmetic:
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: flag_c = borrow (rs1<rs2 unsigned); result wraps modulo 2^DATA_W.
  - flag_z = (result==0).
  - Flags update in WB for ALU ops 1–5 only. LI, MOV, BEQZ and NOP leave flags unchanged.
- next_pc: pc+1, wrapping modulo 2^PC_W. A taken BEQZ uses tgt instead.
- A write to rd=7 is dropped (rf_we stays 0); the pc still advances.
- start outside IDLE/HALT is ignored.
- Reset (asynchronous, any state) forces these values immediately:
  - state=IDLE, pc=0, imem_req=0, rf_we=0
  - rf_a1=rf_a2=rf_a3=0, rf_wd=0
  - halted=0, flag_z=0, flag_c=0
  - An in-flight write is abandoned.

## Timing
- Minimum of 4 cycles per instruction (FETCH, DECODE, READ, WB); FETCH stretches by any imem_valid wait.
- rf_a1/rf_a2 are stable from DECODE through READ. The register file samples them at the DECODE→READ edge.
- rf_a3, rf_wd and rf_we are all valid together in WB. The write commits at the WB→FETCH edge.
- A read in DECODE of the register written by the preceding WB sees the new value, because WB and DECODE are never concurrent.
- imem_valid is sampled only in FETCH; it is ignored in every other state.
- All outputs are registered except rf_we, which is decoded from state plus a registered write-qualify bit.

## Structure
- Package core_pkg holds:
  - opcode enum
  - FSM state enum
  - instruction field bit positions
  - register index R_EXT=3'd7
- Sub-module alu8: combinational; inputs op, a, b; outputs y, c, z. It is instantiated once.
- Decode, FSM and the pc datapath stay in core_sequencer.

## Test plan
- Program LI r1,5; LI r2,3; ADD r3,r1,r2 with imem_valid immediate → third WB has rf_a3=3, rf_wd=8, rf_we=1, flag_z=0, flag_c=0; 12 cycles total after start.
- SUB r4,r2,r1 with r2=3, r1=5 → rf_wd=0xFE, flag_c=1; then SUB r5,r1,r1 → rf_wd=0, flag_z=1, flag_c=0.
- BEQZ on r0=0 with tgt=0x20 → next FETCH pc=0x20. BEQZ on a nonzero register → pc+1. BEQZ at pc=0x3F not taken → pc=0x00 (wrap).
- imem_valid delayed 3 cycles → imem_req stays high and pc is stable for 4 FETCH cycles; DECODE follows on the cycle after imem_valid.
- LI r7,0xAA → rf_we stays 0 throughout WB; pc still increments. HALT → halted=1 until start, then pc=0 and imem_req=1 on the next cycle.
- rst_n asserted low mid-WB → rf_we=0 and pc=0 before the next clock edge; with start low the block remains in IDLE after release.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core sequencer slice.
//   opcode_t   : 4-bit instruction opcodes (9..14 are unassigned and act as NOP)
//   state_t    : sequencer FSM states
//   reg_idx_t  : register file index type
//   *_HI/*_LO  : instruction field bit positions
//   R_EXT      : register index driven externally inside the register file
package core_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_LI   = 4'd6,
    OP_MOV  = 4'd7,
    OP_BEQZ = 4'd8,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_WB,
    ST_HALT
  } state_t;

  typedef logic [2:0] reg_idx_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam reg_idx_t R_EXT = 3'd7;

  // Opcodes that produce a register write-back.
  function automatic logic op_writes(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LI, OP_MOV: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Opcodes that update flag_z / flag_c.
  function automatic logic op_sets_flags(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction-memory handshake and register-file port bundle.
//   imem_req/pc          sequencer -> imem   fetch request and address
//   imem_valid/instr     imem -> sequencer   instruction return
//   rf_a1/rf_a2          sequencer -> rf     read addresses
//   rf_a3/rf_we/rf_wd    sequencer -> rf     write port
//   rf_rd1/rf_rd2        rf -> sequencer     registered read data
// master: sequencer side; slave: memory / register file side.
interface core_sequencer_if
  import core_pkg::*;
#(
  parameter int PC_W   = 6,
  parameter int DATA_W = 8
);
  logic              imem_req;
  logic [PC_W-1:0]   pc;
  logic              imem_valid;
  logic [15:0]       instr;
  reg_idx_t          rf_a1;
  reg_idx_t          rf_a2;
  reg_idx_t          rf_a3;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wd;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;

  modport master (
    output imem_req, pc, rf_a1, rf_a2, rf_a3, rf_we, rf_wd,
    input  imem_valid, instr, rf_rd1, rf_rd2
  );

  modport slave (
    input  imem_req, pc, rf_a1, rf_a2, rf_a3, rf_we, rf_wd,
    output imem_valid, instr, rf_rd1, rf_rd2
  );
endinterface

// File: rtl/core_sequencer_alu8.sv
// alu8: combinational ALU for the sequencer datapath.
//   op : opcode (only ADD/SUB/AND/OR/XOR/MOV produce a result, others give 0)
//   a,b: operands (register file read data)
//   y  : result, modulo 2^DATA_W
//   c  : carry out for ADD, borrow for SUB, 0 otherwise
//   z  : y == 0
module alu8
  import core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z
);
  logic [DATA_W:0] ext;

  // Extended-width arithmetic: the top bit is carry for ADD and borrow for SUB.
  always_comb begin
    ext = '0;
    case (op)
      OP_ADD:  ext = {1'b0, a} + {1'b0, b};
      OP_SUB:  ext = {1'b0, a} - {1'b0, b};
      OP_AND:  ext = {1'b0, a & b};
      OP_OR:   ext = {1'b0, a | b};
      OP_XOR:  ext = {1'b0, a ^ b};
      OP_MOV:  ext = {1'b0, a};
      default: ext = '0;
    endcase
    y = ext[DATA_W-1:0];
    c = ext[DATA_W];
    z = (ext[DATA_W-1:0] == '0);
  end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/read/write-back controller driving
// an 8x8 register file and fetching 16-bit instructions from instruction memory.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : leave IDLE/HALT and fetch from pc=0
//   bus     : imem handshake + register file ports (master side)
//   halted  : high while in HALT
//   flag_z  : zero flag of the last ALU op (ADD..XOR)
//   flag_c  : carry/borrow of the last ALU op (ADD..XOR)
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W   = 6,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  core_sequencer_if.master        bus,
  output logic                    halted,
  output logic                    flag_z,
  output logic                    flag_c
);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t            state;
  logic [15:0]       ir;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   npc_q;
  logic              req_q;
  reg_idx_t          a1_q;
  reg_idx_t          a2_q;
  reg_idx_t          a3_q;
  logic [DATA_W-1:0] wd_q;
  logic              wq_q;

  opcode_t           op;
  reg_idx_t          rd;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic              alu_z;
  logic [DATA_W-1:0] wd_next;
  logic [PC_W-1:0]   next_pc;

  assign op = opcode_t'(ir[OP_HI:OP_LO]);
  assign rd = ir[RD_HI:RD_LO];

  alu8 #(.DATA_W(DATA_W)) u_alu (
    .op (op),
    .a  (bus.rf_rd1),
    .b  (bus.rf_rd2),
    .y  (alu_y),
    .c  (alu_c),
    .z  (alu_z)
  );

  // Write-back data and branch target, evaluated in READ when read data is valid.
  always_comb begin
    wd_next = alu_y;
    if (op == OP_LI)
      wd_next = DATA_W'(ir[IMM_HI:IMM_LO]);
    next_pc = pc_q + PC_ONE;
    if (op == OP_BEQZ && bus.rf_rd1 == '0)
      next_pc = ir[PC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ir     <= '0;
      pc_q   <= '0;
      npc_q  <= '0;
      req_q  <= 1'b0;
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      wd_q   <= '0;
      wq_q   <= 1'b0;
      halted <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc_q  <= '0;
            req_q <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.imem_valid) begin
            // Read addresses are taken from the incoming word so they are
            // already registered and stable for the whole DECODE cycle.
            ir    <= bus.instr;
            a1_q  <= bus.instr[RS1_HI:RS1_LO];
            a2_q  <= bus.instr[RS2_HI:RS2_LO];
            req_q <= 1'b0;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          wd_q  <= wd_next;
          a3_q  <= rd;
          wq_q  <= op_writes(op) && (rd != R_EXT);
          npc_q <= next_pc;
          // Flags are registered here so the new values are visible in WB.
          if (op_sets_flags(op)) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
          end
          state <= ST_WB;
        end
        ST_WB: begin
          pc_q  <= npc_q;
          wq_q  <= 1'b0;
          req_q <= 1'b1;
          state <= ST_FETCH;
        end
        ST_HALT: begin
          if (start) begin
            halted <= 1'b0;
            pc_q   <= '0;
            req_q  <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_req = req_q;
  assign bus.pc       = pc_q;
  assign bus.rf_a1    = a1_q;
  assign bus.rf_a2    = a2_q;
  assign bus.rf_a3    = a3_q;
  assign bus.rf_wd    = wd_q;
  // Decoded from state so a reset drops an in-flight write immediately.
  assign bus.rf_we    = (state == ST_WB) && wq_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed + randomized check of core_sequencer against an
// instruction-level reference model; a simple 8x8 register file with r7 tied
// to an external value surrounds the DUT.
module tb_core_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halted, flag_z, flag_c;

  core_sequencer_if #(.PC_W(6), .DATA_W(8)) bus ();

  core_sequencer #(.PC_W(6), .DATA_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .halted (halted),
    .flag_z (flag_z),
    .flag_c (flag_c)
  );

  always #5 clk = ~clk;

  // Register file environment: registered reads, write on the clock edge.
  logic [7:0] rf [8];
  logic [7:0] ext7;
  always @(posedge clk) begin
    if (bus.rf_we && bus.rf_a3 != 3'd7)
      rf[bus.rf_a3] <= bus.rf_wd;
    bus.rf_rd1 <= (bus.rf_a1 == 3'd7) ? ext7 : rf[bus.rf_a1];
    bus.rf_rd2 <= (bus.rf_a2 == 3'd7) ? ext7 : rf[bus.rf_a2];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Architectural reference state.
  int m_reg [8];
  int m_pc;
  bit m_z, m_c;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting from a FETCH cycle (sampled at negedge).
  task automatic exec(input logic [15:0] ins, input int delay, input bit rst_wb);
    int op, rd, rs1, rs2, imm, tgt, a, b, res, npc;
    bit we, setf, nz, nc;
    op  = ins[15:12];
    rd  = ins[11:9];
    rs1 = ins[8:6];
    rs2 = ins[5:3];
    imm = ins[7:0];
    tgt = ins[5:0];
    a = m_reg[rs1];
    b = m_reg[rs2];
    we = 0; setf = 0; res = 0; nz = m_z; nc = m_c;
    npc = (m_pc + 1) % 64;
    case (op)
      1: begin res = a + b; nc = (res > 255); res = res % 256; setf = 1; we = 1; end
      2: begin nc = (a < b); res = (a - b + 256) % 256; setf = 1; we = 1; end
      3: begin res = a & b; nc = 0; setf = 1; we = 1; end
      4: begin res = a | b; nc = 0; setf = 1; we = 1; end
      5: begin res = a ^ b; nc = 0; setf = 1; we = 1; end
      6: begin res = imm; we = 1; end
      7: begin res = a; we = 1; end
      8: if (a == 0) npc = tgt;
      default: ;
    endcase
    if (setf) nz = (res == 0);
    if (rd == 7) we = 0;

    // FETCH, optionally stretched
    for (int k = 0; k < delay; k++) begin
      bus.imem_valid = 1'b0;
      bus.instr = 16'($urandom);
      chk("fetch_wait_req", bus.imem_req, 1);
      chk("fetch_wait_pc", bus.pc, m_pc);
      @(negedge clk);
    end
    chk("fetch_req", bus.imem_req, 1);
    chk("fetch_pc", bus.pc, m_pc);
    bus.imem_valid = 1'b1;
    bus.instr = ins;
    @(negedge clk);

    // DECODE: noise on ignored inputs
    bus.imem_valid = 1'($urandom_range(0, 1));
    bus.instr = 16'($urandom);
    start = 1'($urandom_range(0, 1));
    chk("decode_req", bus.imem_req, 0);
    chk("decode_we", bus.rf_we, 0);
    chk("decode_halted", halted, 0);
    if (op == 15) begin
      @(negedge clk);
      start = 1'b0;
      bus.imem_valid = 1'b0;
      return;
    end
    chk("decode_a1", bus.rf_a1, rs1);
    chk("decode_a2", bus.rf_a2, rs2);
    @(negedge clk);

    // READ
    bus.imem_valid = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1));
    chk("read_a1", bus.rf_a1, rs1);
    chk("read_a2", bus.rf_a2, rs2);
    chk("read_we", bus.rf_we, 0);
    @(negedge clk);

    // WB
    start = 1'b0;
    bus.imem_valid = 1'b0;
    chk("wb_we", bus.rf_we, we);
    if (we) begin
      chk("wb_a3", bus.rf_a3, rd);
      chk("wb_wd", bus.rf_wd, res);
    end
    chk("wb_flag_z", flag_z, nz);
    chk("wb_flag_c", flag_c, nc);
    if (rst_wb) begin
      rst_n = 1'b0;
      #1;
      chk("rst_wb_we", bus.rf_we, 0);
      chk("rst_wb_pc", bus.pc, 0);
      chk("rst_wb_req", bus.imem_req, 0);
      chk("rst_wb_a1", bus.rf_a1, 0);
      chk("rst_wb_wd", bus.rf_wd, 0);
      chk("rst_wb_flags", {flag_z, flag_c, halted}, 0);
      m_pc = 0; m_z = 0; m_c = 0;
      return;
    end
    if (we) m_reg[rd] = res;
    m_z = nz;
    m_c = nc;
    m_pc = npc;
    @(negedge clk);

    // next FETCH
    chk("next_pc", bus.pc, m_pc);
    chk("next_req", bus.imem_req, 1);
  endtask

  initial begin
    int c0;
    logic [15:0] rins;
    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'h00;
      m_reg[i] = 0;
    end
    ext7 = 8'($urandom_range(1, 255));
    m_reg[7] = ext7;
    m_pc = 0; m_z = 0; m_c = 0;
    bus.imem_valid = 1'b0;
    bus.instr = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.pc, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_a1", bus.rf_a1, 0);
    chk("rst_a2", bus.rf_a2, 0);
    chk("rst_a3", bus.rf_a3, 0);
    chk("rst_wd", bus.rf_wd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_c", flag_c, 0);
    rst_n = 1'b1;
    repeat (3) begin
      bus.imem_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_req", bus.imem_req, 0);
    end
    bus.imem_valid = 1'b0;

    // LI r1,5; LI r2,3; ADD r3,r1,r2
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    exec(16'h6205, 0, 0);
    exec(16'h6403, 0, 0);
    exec(16'h1650, 0, 0);
    // start edge plus 3 x 4 cycles, now sitting in the following FETCH
    chk("three_instr_cycles", cyc - c0, 13);

    // SUB borrow, then SUB to zero
    exec(16'h2888, 0, 0);
    exec(16'h2A48, 0, 0);

    // BEQZ taken, not taken, and wrap from 0x3F
    exec(16'h8020, 0, 0);
    exec(16'h8050, 0, 0);
    exec(16'h803F, 0, 0);
    exec(16'h8045, 1, 0);

    // Stretched fetch, then write to r7 dropped
    exec(16'h6C77, 3, 0);
    exec(16'h6EAA, 0, 0);

    // Randomized instruction stream (no HALT)
    for (int n = 0; n < 80; n++) begin
      rins = 16'($urandom);
      rins[15:12] = 4'($urandom_range(0, 14));
      exec(rins, $urandom_range(0, 3), 0);
    end

    // HALT and restart
    exec(16'hF000, 1, 0);
    for (int k = 0; k < 3; k++) begin
      bus.imem_valid = 1'($urandom_range(0, 1));
      chk("halt_halted", halted, 1);
      chk("halt_req", bus.imem_req, 0);
      @(negedge clk);
    end
    bus.imem_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 0;
    chk("restart_halted", halted, 0);
    chk("restart_pc", bus.pc, 0);
    chk("restart_req", bus.imem_req, 1);
    exec(16'h6242, 0, 0);

    // Reset in the middle of WB abandons the write
    exec(16'h6411, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_req", bus.imem_req, 0);
      chk("post_rst_pc", bus.pc, 0);
      chk("post_rst_we", bus.rf_we, 0);
    end
    for (int i = 0; i < 7; i++)
      chk("final_regs", rf[i], m_reg[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
